// File: rtl/vga_timing_gen.sv
// Raster timing generator: 800x600@60 pixel coordinates, syncs, video_on and line/frame ticks.
// Define VGA_FRAME_COUNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
    parameter int PIX_DIV = 1,
    parameter int H_VIS   = 800,
    parameter int H_FP    = 40,
    parameter int H_SYNC  = 128,
    parameter int H_BP    = 88,
    parameter int V_VIS   = 600,
    parameter int V_FP    = 1,
    parameter int V_SYNC  = 4,
    parameter int V_BP    = 23
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] X,
    output logic [10:0] Y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        pix_en,
    output logic        line_tick,
`ifdef VGA_FRAME_COUNT_EN
    output logic        frame_tick,
    output logic [15:0] frame_cnt
`else
    output logic        frame_tick
`endif
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] Y_FRAME  = 11'(V_VIS - 1);
    localparam logic [10:0] X_VIS    = 11'(H_VIS);
    localparam logic [10:0] Y_VIS    = 11'(V_VIS);
    localparam logic [10:0] HS_FIRST = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_VIS + V_FP + V_SYNC - 1);

    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_range_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
    end
    if (PIX_DIV < 1) begin : g_div_check
        $error("vga_timing_gen: PIX_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [10:0]      x_nxt;
    logic [10:0]      y_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign pix_en = (div_cnt == DIV_LAST);

    always_comb begin
        x_nxt = X;
        y_nxt = Y;
        if (pix_en) begin
            if (X == X_LAST) begin
                x_nxt = '0;
                y_nxt = (Y == Y_LAST) ? '0 : Y + 11'd1;
            end else begin
                x_nxt = X + 11'd1;
            end
        end
    end

    // Sync/blank flags are decoded from x_nxt/y_nxt so the registered flags line up with X/Y.
    always_ff @(posedge clk) begin
        if (reset) begin
            X        <= '0;
            Y        <= '0;
            hsync    <= 1'b0;
            vsync    <= 1'b0;
            video_on <= 1'b1;
        end else begin
            X        <= x_nxt;
            Y        <= y_nxt;
            hsync    <= (x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST);
            vsync    <= (y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST);
            video_on <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
        end
    end

    assign line_tick  = pix_en & (X == X_LAST);
    assign frame_tick = line_tick & (Y == Y_FRAME);

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

    x_in_range: assert property (@(posedge clk) disable iff (reset) X <= X_LAST);
    y_in_range: assert property (@(posedge clk) disable iff (reset) Y <= Y_LAST);
    y_moves_on_wrap: assert property (@(posedge clk) disable iff (reset) !line_tick |=> $stable(Y));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance plus two shrunken rasters (PIX_DIV 1 and 2).
// Expected outputs come from a per-instance raster model queued each cycle and popped after the edge.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        von;
        logic        pen;
        logic        lt;
        logic        ft;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_d = 1'b1;
    logic rst_s = 1'b1;
    logic rst_p = 1'b1;

    logic [10:0] X_d, Y_d, X_s, Y_s, X_p, Y_p;
    logic hs_d, vs_d, von_d, pen_d, lt_d, ft_d;
    logic hs_s, vs_s, von_s, pen_s, lt_s, ft_s;
    logic hs_p, vs_p, von_p, pen_p, lt_p, ft_p;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] fc_d, fc_s, fc_p;
`endif

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk(clk), .reset(rst_d), .X(X_d), .Y(Y_d), .hsync(hs_d), .vsync(vs_d),
        .video_on(von_d), .pix_en(pen_d), .line_tick(lt_d),
`ifdef VGA_FRAME_COUNT_EN
        .frame_tick(ft_d), .frame_cnt(fc_d)
`else
        .frame_tick(ft_d)
`endif
    );

    vga_timing_gen #(
        .PIX_DIV(1), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut_s (
        .clk(clk), .reset(rst_s), .X(X_s), .Y(Y_s), .hsync(hs_s), .vsync(vs_s),
        .video_on(von_s), .pix_en(pen_s), .line_tick(lt_s),
`ifdef VGA_FRAME_COUNT_EN
        .frame_tick(ft_s), .frame_cnt(fc_s)
`else
        .frame_tick(ft_s)
`endif
    );

    vga_timing_gen #(
        .PIX_DIV(2), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut_p (
        .clk(clk), .reset(rst_p), .X(X_p), .Y(Y_p), .hsync(hs_p), .vsync(vs_p),
        .video_on(von_p), .pix_en(pen_p), .line_tick(lt_p),
`ifdef VGA_FRAME_COUNT_EN
        .frame_tick(ft_p), .frame_cnt(fc_p)
`else
        .frame_tick(ft_p)
`endif
    );

    int pd[3]  = '{1, 1, 2};
    int hv[3]  = '{800, 16, 16};
    int hf[3]  = '{40, 2, 2};
    int hsw[3] = '{128, 4, 4};
    int hb[3]  = '{88, 3, 3};
    int vv[3]  = '{600, 8, 8};
    int vf[3]  = '{1, 1, 1};
    int vsw[3] = '{4, 2, 2};
    int vb[3]  = '{23, 2, 2};

    int mx[3];
    int my[3];
    int md[3];
    logic [15:0] mfc[3];

    exp_t sb_d[$];
    exp_t sb_s[$];
    exp_t sb_p[$];

    int vectors = 0;
    int miscompares = 0;

    function automatic exp_t expect_of(input int i);
        exp_t e;
        int ht = hv[i] + hf[i] + hsw[i] + hb[i];
        e.x   = 11'(mx[i]);
        e.y   = 11'(my[i]);
        e.pen = (md[i] == pd[i] - 1);
        e.hs  = (mx[i] >= hv[i] + hf[i]) && (mx[i] < hv[i] + hf[i] + hsw[i]);
        e.vs  = (my[i] >= vv[i] + vf[i]) && (my[i] < vv[i] + vf[i] + vsw[i]);
        e.von = (mx[i] < hv[i]) && (my[i] < vv[i]);
        e.lt  = e.pen && (mx[i] == ht - 1);
        e.ft  = e.lt && (my[i] == vv[i] - 1);
        e.fc  = mfc[i];
        return e;
    endfunction

    function automatic void model_step(input int i, input logic r);
        exp_t e = expect_of(i);
        int ht = hv[i] + hf[i] + hsw[i] + hb[i];
        int vt = vv[i] + vf[i] + vsw[i] + vb[i];
        if (r) begin
            mx[i] = 0; my[i] = 0; md[i] = 0; mfc[i] = '0;
        end else begin
`ifdef VGA_FRAME_COUNT_EN
            if (e.ft) mfc[i] = mfc[i] + 16'd1;
`endif
            if (e.pen) begin
                if (mx[i] == ht - 1) begin
                    mx[i] = 0;
                    my[i] = (my[i] == vt - 1) ? 0 : my[i] + 1;
                end else begin
                    mx[i] = mx[i] + 1;
                end
            end
            md[i] = (md[i] == pd[i] - 1) ? 0 : md[i] + 1;
        end
    endfunction

    function automatic exp_t obs_of(input int i);
        exp_t o;
        case (i)
            0: o = '{x: X_d, y: Y_d, hs: hs_d, vs: vs_d, von: von_d, pen: pen_d, lt: lt_d, ft: ft_d, fc: 16'd0};
            1: o = '{x: X_s, y: Y_s, hs: hs_s, vs: vs_s, von: von_s, pen: pen_s, lt: lt_s, ft: ft_s, fc: 16'd0};
            default: o = '{x: X_p, y: Y_p, hs: hs_p, vs: vs_p, von: von_p, pen: pen_p, lt: lt_p, ft: ft_p, fc: 16'd0};
        endcase
`ifdef VGA_FRAME_COUNT_EN
        case (i)
            0: o.fc = fc_d;
            1: o.fc = fc_s;
            default: o.fc = fc_p;
        endcase
`endif
        return o;
    endfunction

    function automatic exp_t pop_exp(input int i);
        case (i)
            0: return sb_d.pop_front();
            1: return sb_s.pop_front();
            default: return sb_p.pop_front();
        endcase
    endfunction

    task automatic drive_cycle(input logic rd, input logic rs, input logic rp);
        rst_d = rd;
        rst_s = rs;
        rst_p = rp;
        model_step(0, rd);
        model_step(1, rs);
        model_step(2, rp);
        sb_d.push_back(expect_of(0));
        sb_s.push_back(expect_of(1));
        sb_p.push_back(expect_of(2));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b1, 1'b1, 1'b1);
            for (int i = 0; i < 3; i++) begin
                e = pop_exp(i); o = obs_of(i); vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL reset inst%0d: got x=%0d y=%0d f=%b fc=%0d, expected x=%0d y=%0d f=%b fc=%0d",
                             i, o.x, o.y, {o.hs, o.vs, o.von, o.pen, o.lt, o.ft}, o.fc,
                             e.x, e.y, {e.hs, e.vs, e.von, e.pen, e.lt, e.ft}, e.fc);
                end
            end
        end
        vectors++;
        if ({X_d, Y_d, hs_d, vs_d, von_d, pen_d, lt_d, ft_d} !== {11'd0, 11'd0, 6'b001100}) begin
            miscompares++;
            $display("FAIL reset_values: got X=%0d Y=%0d hs/vs/von/pen/lt/ft=%b, expected 0 0 001100",
                     X_d, Y_d, {hs_d, vs_d, von_d, pen_d, lt_d, ft_d});
        end
        vectors++;
        if (pen_p !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pix_en_div2: got %b, expected 0", pen_p);
        end
        drive_cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            e = pop_exp(i); o = obs_of(i); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL release inst%0d: got x=%0d y=%0d f=%b, expected x=%0d y=%0d f=%b",
                         i, o.x, o.y, {o.hs, o.vs, o.von, o.pen, o.lt, o.ft},
                         e.x, e.y, {e.hs, e.vs, e.von, e.pen, e.lt, e.ft});
            end
        end
        vectors++;
        if (X_d !== 11'd1 || X_p !== 11'd0) begin
            miscompares++;
            $display("FAIL first_step: got X_d=%0d X_p=%0d, expected 1 and 0", X_d, X_p);
        end
    endtask

    task automatic test_line();
        exp_t e, o;
        int hs_cnt = 0, hs_first = -1, hs_last = -1, lt_cnt = 0, lt_x = -1, von_fall = -1;
        int prev_x = 1;
        logic von_prev = 1'b1;
        logic wrap_ok = 1'b0;
        for (int c = 0; c < 1060; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                e = pop_exp(i); o = obs_of(i); vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL line inst%0d: got x=%0d y=%0d f=%b, expected x=%0d y=%0d f=%b",
                             i, o.x, o.y, {o.hs, o.vs, o.von, o.pen, o.lt, o.ft},
                             e.x, e.y, {e.hs, e.vs, e.von, e.pen, e.lt, e.ft});
                end
            end
            if (hs_d) begin
                if (hs_first < 0) hs_first = int'(X_d);
                hs_last = int'(X_d);
                hs_cnt++;
            end
            if (lt_d) begin lt_cnt++; lt_x = int'(X_d); end
            if (von_prev && !von_d && von_fall < 0) von_fall = int'(X_d);
            von_prev = von_d;
            if (X_d == 11'd0 && Y_d == 11'd1 && prev_x == 1055) wrap_ok = 1'b1;
            prev_x = int'(X_d);
        end
        vectors++;
        if (hs_cnt != 128 || hs_first != 840 || hs_last != 967) begin
            miscompares++;
            $display("FAIL hsync_window: got %0d clks X=%0d..%0d, expected 128 clks X=840..967", hs_cnt, hs_first, hs_last);
        end
        vectors++;
        if (lt_cnt != 1 || lt_x != 1055) begin
            miscompares++;
            $display("FAIL line_tick: got %0d pulses at X=%0d, expected 1 at X=1055", lt_cnt, lt_x);
        end
        vectors++;
        if (von_fall != 800) begin
            miscompares++;
            $display("FAIL video_on_fall: got X=%0d, expected 800", von_fall);
        end
        vectors++;
        if (!wrap_ok) begin
            miscompares++;
            $display("FAIL line_wrap: got no 1055->0 with Y 0->1, expected it");
        end
    endtask

    task automatic test_frame();
        exp_t e, o;
        int ticks[$];
        int vs_cnt = 0, wraps = 0, bad_xy = 0, prev_y = 0;
        drive_cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            e = pop_exp(i); o = obs_of(i); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL frame_reset inst%0d: got x=%0d y=%0d, expected x=%0d y=%0d", i, o.x, o.y, e.x, e.y);
            end
        end
        for (int c = 1; c <= 985; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                e = pop_exp(i); o = obs_of(i); vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL frame inst%0d c=%0d: got x=%0d y=%0d f=%b fc=%0d, expected x=%0d y=%0d f=%b fc=%0d",
                             i, c, o.x, o.y, {o.hs, o.vs, o.von, o.pen, o.lt, o.ft}, o.fc,
                             e.x, e.y, {e.hs, e.vs, e.von, e.pen, e.lt, e.ft}, e.fc);
                end
            end
`ifdef VGA_FRAME_COUNT_EN
            if (ticks.size() > 0 && c == ticks[$] + 1) begin
                vectors++;
                if (fc_s !== 16'(ticks.size())) begin
                    miscompares++;
                    $display("FAIL frame_cnt_step: got %0d after tick, expected %0d", fc_s, ticks.size());
                end
            end
`endif
            if (ft_s) begin
                ticks.push_back(c);
                if (X_s != 11'd24 || Y_s != 11'd7) bad_xy++;
            end
            if (vs_s) vs_cnt++;
            if (Y_s == 11'd0 && prev_y == 12) wraps++;
            prev_y = int'(Y_s);
        end
        vectors++;
        if (ticks.size() != 3) begin
            miscompares++;
            $display("FAIL frame_tick_count: got %0d, expected 3", ticks.size());
        end else begin
            vectors++;
            if (ticks[0] != 199 || ticks[1] - ticks[0] != 325 || ticks[2] - ticks[1] != 325) begin
                miscompares++;
                $display("FAIL frame_tick_period: got %0d,%0d,%0d, expected 199,524,849", ticks[0], ticks[1], ticks[2]);
            end
        end
        vectors++;
        if (bad_xy != 0) begin
            miscompares++;
            $display("FAIL frame_tick_pos: got %0d ticks off (24,7), expected 0", bad_xy);
        end
        vectors++;
        if (vs_cnt != 150) begin
            miscompares++;
            $display("FAIL vsync_width: got %0d clks, expected 150", vs_cnt);
        end
        vectors++;
        if (wraps != 3) begin
            miscompares++;
            $display("FAIL y_wrap: got %0d wraps 12->0, expected 3", wraps);
        end
    endtask

    task automatic test_pix_div();
        exp_t e, o;
        int ticks[$];
        int pen_cnt = 0, hold_bad = 0, toggle_bad = 0, run = 1;
        logic [10:0] prev_x;
        logic prev_pen;
        drive_cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            e = pop_exp(i); o = obs_of(i); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL pixdiv_reset inst%0d: got x=%0d pen=%b, expected x=%0d pen=%b", i, o.x, o.pen, e.x, e.pen);
            end
        end
        prev_x = X_p;
        prev_pen = pen_p;
        for (int c = 1; c <= 1320; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                e = pop_exp(i); o = obs_of(i); vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL pixdiv inst%0d c=%0d: got x=%0d y=%0d f=%b, expected x=%0d y=%0d f=%b",
                             i, c, o.x, o.y, {o.hs, o.vs, o.von, o.pen, o.lt, o.ft},
                             e.x, e.y, {e.hs, e.vs, e.von, e.pen, e.lt, e.ft});
                end
            end
            if (pen_p) pen_cnt++;
            if (pen_p === prev_pen) toggle_bad++;
            prev_pen = pen_p;
            if (X_p != prev_x) begin
                if (run != 2) hold_bad++;
                run = 1;
            end else begin
                run++;
            end
            prev_x = X_p;
            if (ft_p) ticks.push_back(c);
        end
        vectors++;
        if (pen_cnt != 660 || toggle_bad != 0) begin
            miscompares++;
            $display("FAIL pix_en_rate: got %0d strobes, %0d non-toggles, expected 660 and 0", pen_cnt, toggle_bad);
        end
        vectors++;
        if (hold_bad != 0) begin
            miscompares++;
            $display("FAIL x_hold: got %0d X values not held 2 clks, expected 0", hold_bad);
        end
        vectors++;
        if (ticks.size() != 2) begin
            miscompares++;
            $display("FAIL pixdiv_tick_count: got %0d, expected 2", ticks.size());
        end else begin
            vectors++;
            if (ticks[0] != 399 || ticks[1] - ticks[0] != 650) begin
                miscompares++;
                $display("FAIL pixdiv_tick_period: got %0d,%0d, expected 399,1049", ticks[0], ticks[1]);
            end
        end
    endtask

    task automatic test_abort();
        exp_t e, o;
        logic found = 1'b0;
        int lt_cnt = 0, lt_first = -1, ft_cnt = 0;
        for (int c = 0; c < 400 && !found; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                e = pop_exp(i); o = obs_of(i); vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL abort_run inst%0d: got x=%0d y=%0d, expected x=%0d y=%0d", i, o.x, o.y, e.x, e.y);
                end
            end
            if (X_s == 11'd10 && Y_s == 11'd5) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL abort_wait: got no X=10 Y=5 within 400 clks, expected it");
        end else begin
            vectors++;
            if (lt_s !== 1'b0 || ft_s !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_tick_during: got lt=%b ft=%b, expected 0 0", lt_s, ft_s);
            end
            drive_cycle(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < 3; i++) begin
                e = pop_exp(i); o = obs_of(i); vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL abort_reset inst%0d: got x=%0d y=%0d, expected x=%0d y=%0d", i, o.x, o.y, e.x, e.y);
                end
            end
            vectors++;
            if (X_s !== 11'd0 || Y_s !== 11'd0) begin
                miscompares++;
                $display("FAIL abort_restart: got X=%0d Y=%0d, expected 0 0", X_s, Y_s);
            end
            for (int c = 1; c <= 30; c++) begin
                drive_cycle(1'b0, 1'b0, 1'b0);
                for (int i = 0; i < 3; i++) begin
                    e = pop_exp(i); o = obs_of(i); vectors++;
                    if (o !== e) begin
                        miscompares++;
                        $display("FAIL abort_after inst%0d: got x=%0d y=%0d, expected x=%0d y=%0d", i, o.x, o.y, e.x, e.y);
                    end
                end
                if (lt_s) begin
                    lt_cnt++;
                    if (lt_first < 0) lt_first = c;
                end
                if (ft_s) ft_cnt++;
            end
            vectors++;
            if (lt_cnt != 1 || lt_first != 24 || ft_cnt != 0) begin
                miscompares++;
                $display("FAIL abort_ticks_after: got lt=%0d first@%0d ft=%0d, expected 1 @24 and 0", lt_cnt, lt_first, ft_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_pix_div();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
